sobel_window_gen: RTL and testbench

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

---
 rtl/sobel_window_gen_pkg.sv | 22 ++
 rtl/sobel_line_buffer.sv | 39 +++
 rtl/sobel_window_gen.sv | 162 ++++++++++++++++
 tb/tb_sobel_window_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_gen_pkg
//  Description : Shared definitions for the sobel pipeline stages: default
//                image geometry / pixel width and the window-generator FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sobel_window_gen_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 16;
    localparam int DEF_IMG_H  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for the first pixel of a frame
        ST_FILL = 2'd1,   // receiving rows 0..1, no windows possible yet
        ST_RUN  = 2'd2    // rows 2..IMG_H-1, windows being produced
    } sobel_state_t;

endpackage : sobel_window_gen_pkg
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_line_buffer
//  Description : One image line of storage (DEPTH x DATA_W). The read port
//                returns the entry currently stored at i_addr, and the same
//                address is overwritten with i_wdata at the clock edge, so a
//                read always sees the previous line's pixel for that column.
//  Ports       : clk      - clock
//                i_we     - write enable (pixel accepted)
//                i_addr   - column address
//                i_wdata  - pixel to store
//                o_rdata  - pixel previously stored at i_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // Contents are deliberately not reset: rows are always rewritten before
    // they can contribute to a window.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule : sobel_line_buffer
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_gen
//  Description : Builds 3x3 pixel windows from a raster-order pixel stream
//                using two line buffers and a 3-column shift register per
//                row. A window is emitted (registered) one cycle after the
//                pixel completing it is accepted; border centres produce no
//                window.
//  Ports       : clk, reset (async, active high)
//                in_valid / in_sof / in_pixel - pixel stream, no backpressure
//                win_valid  - win holds a complete window
//                win        - w00 (top-left) in MSBs .. w22 in LSBs
//                win_row/col- window centre coordinates
//                done       - pulse with the last window of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_W-1:0]        in_pixel,
    output logic                     win_valid,
    output logic [9*DATA_W-1:0]      win,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] c_last_col = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_last_row = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_two_col  = CW'(2);
    localparam logic [RW-1:0] c_two_row  = RW'(2);

    sobel_state_t      r_state;
    logic [CW-1:0]     r_col;       // position the next pixel will take
    logic [RW-1:0]     r_row;

    // Shift registers: index 0 is column c-2, index 1 is column c-1.
    logic [DATA_W-1:0] r_top0, r_top1;
    logic [DATA_W-1:0] r_mid0, r_mid1;
    logic [DATA_W-1:0] r_bot0, r_bot1;

    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic [DATA_W-1:0] w_lb0_rd;    // row r-1 at this column
    logic [DATA_W-1:0] w_lb1_rd;    // row r-2 at this column
    logic              w_win_ok;
    logic              w_last;

    // A start-of-frame marker, or any pixel arriving while idle, restarts
    // the raster position at (0,0).
    assign w_col    = (in_sof || (r_state == ST_IDLE)) ? '0 : r_col;
    assign w_row    = (in_sof || (r_state == ST_IDLE)) ? '0 : r_row;
    assign w_win_ok = (w_row >= c_two_row) && (w_col >= c_two_col);
    assign w_last   = (w_row == c_last_row) && (w_col == c_last_col);

    // lb0 holds the previous line; its outgoing entry cascades into lb1.
    sobel_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (in_valid),
        .i_addr  (w_col),
        .i_wdata (in_pixel),
        .o_rdata (w_lb0_rd)
    );

    sobel_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (in_valid),
        .i_addr  (w_col),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_top0    <= '0;
            r_top1    <= '0;
            r_mid0    <= '0;
            r_mid1    <= '0;
            r_bot0    <= '0;
            r_bot1    <= '0;
            win_valid <= 1'b0;
            done      <= 1'b0;
            win       <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= 1'b0;
            done      <= 1'b0;
            if (in_valid) begin
                // Raster position advance
                if (w_col == c_last_col) begin
                    r_col <= '0;
                    r_row <= (w_row == c_last_row) ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end

                r_top0 <= r_top1;
                r_top1 <= w_lb1_rd;
                r_mid0 <= r_mid1;
                r_mid1 <= w_lb0_rd;
                r_bot0 <= r_bot1;
                r_bot1 <= in_pixel;

                // Stale shift-register columns left over from the previous
                // line are never used: c >= 2 guarantees both were loaded
                // from the current line.
                if (w_win_ok) begin
                    win_valid <= 1'b1;
                    done      <= w_last;
                    win       <= {r_top0, r_top1, w_lb1_rd,
                                  r_mid0, r_mid1, w_lb0_rd,
                                  r_bot0, r_bot1, in_pixel};
                    win_row   <= w_row - RW'(1);
                    win_col   <= w_col - CW'(1);
                end

                if (in_sof) begin
                    r_state <= ST_FILL;
                end else begin
                    case (r_state)
                        ST_IDLE: r_state <= ST_FILL;
                        ST_FILL: begin
                            if ((w_row == c_two_row) && (w_col == '0)) begin
                                r_state <= ST_RUN;
                            end
                        end
                        ST_RUN: begin
                            if (w_last) begin
                                r_state <= ST_IDLE;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule : sobel_window_gen
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_window_gen
//  Description : Self-checking bench for sobel_window_gen. Drives a 5x5 and
//                a 3x3 instance and compares every output cycle against a
//                frame-array reference model of the windowing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 5x5 instance
    logic        a_valid, a_sof;
    logic [7:0]  a_pixel;
    logic        a_wv, a_done;
    logic [71:0] a_win;
    logic [2:0]  a_row, a_col;

    // 3x3 instance
    logic        b_valid, b_sof;
    logic [7:0]  b_pixel;
    logic        b_wv, b_done;
    logic [71:0] b_win;
    logic [1:0]  b_row, b_col;

    sobel_window_gen #(.DATA_W(8), .IMG_W(5), .IMG_H(5)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_valid),
        .in_sof    (a_sof),
        .in_pixel  (a_pixel),
        .win_valid (a_wv),
        .win       (a_win),
        .win_row   (a_row),
        .win_col   (a_col),
        .done      (a_done)
    );

    sobel_window_gen #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_valid),
        .in_sof    (b_sof),
        .in_pixel  (b_pixel),
        .win_valid (b_wv),
        .win       (b_win),
        .win_row   (b_row),
        .win_col   (b_col),
        .done      (b_done)
    );

    int          n_total = 0;
    int          n_bad   = 0;

    // Reference model state, per instance
    logic [7:0]  img [2][5][5];
    int          m_r [2];
    int          m_c [2];
    logic [71:0] last_win [2];
    logic [7:0]  last_row [2];
    logic [7:0]  last_col [2];
    int          wins  [2];
    int          dones [2];

    function automatic int dim(input int s);
        return (s == 0) ? 5 : 3;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_total++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_r[s]      = 0;
            m_c[s]      = 0;
            last_win[s] = '0;
            last_row[s] = '0;
            last_col[s] = '0;
        end
    endtask

    task automatic check_zero(input int s, input string tag);
        if (s == 0) begin
            chk({tag, "_a_wv"},   72'(a_wv),   72'd0);
            chk({tag, "_a_done"}, 72'(a_done), 72'd0);
            chk({tag, "_a_win"},  a_win,       72'd0);
            chk({tag, "_a_row"},  72'(a_row),  72'd0);
            chk({tag, "_a_col"},  72'(a_col),  72'd0);
        end else begin
            chk({tag, "_b_wv"},   72'(b_wv),   72'd0);
            chk({tag, "_b_done"}, 72'(b_done), 72'd0);
            chk({tag, "_b_win"},  b_win,       72'd0);
            chk({tag, "_b_row"},  72'(b_row),  72'd0);
            chk({tag, "_b_col"},  72'(b_col),  72'd0);
        end
    endtask

    // One clock cycle on instance s: optionally accept a pixel, then check
    // every output against the model.
    task automatic step(input int s, input bit v, input bit sof, input logic [7:0] px);
        bit          exp_v, exp_d, ov, od;
        int          r, c, n;
        logic [71:0] ew, ow;
        logic [7:0]  orow, ocol;
        n       = dim(s);
        a_valid = (s == 0) && v;
        a_sof   = (s == 0) && v && sof;
        a_pixel = px;
        b_valid = (s == 1) && v;
        b_sof   = (s == 1) && v && sof;
        b_pixel = px;
        @(posedge clk);
        #1;
        exp_v = 1'b0;
        exp_d = 1'b0;
        if (v) begin
            if (sof) begin
                m_r[s] = 0;
                m_c[s] = 0;
            end
            r = m_r[s];
            c = m_c[s];
            img[s][r][c] = px;
            if (r >= 2 && c >= 2) begin
                ew = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew = {ew[63:0], img[s][r-2+i][c-2+j]};
                exp_v       = 1'b1;
                exp_d       = (r == n - 1) && (c == n - 1);
                last_win[s] = ew;
                last_row[s] = 8'(r - 1);
                last_col[s] = 8'(c - 1);
            end
            c = c + 1;
            if (c == n) begin
                c = 0;
                r = (r + 1) % n;
            end
            m_r[s] = r;
            m_c[s] = c;
        end
        if (s == 0) begin
            ov = a_wv; od = a_done; ow = a_win; orow = 8'(a_row); ocol = 8'(a_col);
        end else begin
            ov = b_wv; od = b_done; ow = b_win; orow = 8'(b_row); ocol = 8'(b_col);
        end
        chk("win_valid", 72'(ov),   72'(exp_v));
        chk("done",      72'(od),   72'(exp_d));
        chk("win",       ow,        last_win[s]);
        chk("win_row",   72'(orow), 72'(last_row[s]));
        chk("win_col",   72'(ocol), 72'(last_col[s]));
        if (ov) wins[s]++;
        if (od) dones[s]++;
    endtask

    // Drive pixels of instance s in raster order, stopping before linear
    // index stop_at. mode 0: pixel = row*16+col, 1: random.
    // gap 0: none, 1: idle before every pixel, 2: random idles.
    task automatic frame(input int s, input int mode, input int gap,
                         input bit use_sof, input int stop_at);
        int n;
        logic [7:0] px;
        n = dim(s);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                if (r * n + c >= stop_at) return;
                if (gap == 1) step(s, 1'b0, 1'b0, 8'd0);
                if (gap == 2) begin
                    int k;
                    k = $urandom_range(0, 2);
                    for (int g = 0; g < k; g++) step(s, 1'b0, 1'b0, 8'($urandom));
                end
                px = (mode == 0) ? 8'(r * 16 + c) : 8'($urandom);
                step(s, 1'b1, use_sof && (r == 0) && (c == 0), px);
                if (s == 0 && mode == 0 && r == 2 && c == 2) begin
                    chk("first_win",     a_win,       72'h00_01_02_10_11_12_20_21_22);
                    chk("first_win_row", 72'(a_row),  72'd1);
                    chk("first_win_col", 72'(a_col),  72'd1);
                end
            end
        end
    endtask

    task automatic clear_counts();
        wins[0] = 0; wins[1] = 0; dones[0] = 0; dones[1] = 0;
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0; a_sof = 1'b0; a_pixel = '0;
        b_valid = 1'b0; b_sof = 1'b0; b_pixel = '0;
        model_reset();
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset");
        check_zero(1, "reset");
        reset = 1'b0;

        // 5x5 coordinate pattern, continuous
        clear_counts();
        frame(0, 0, 0, 1'b1, 25);
        step(0, 1'b0, 1'b0, 8'd0);
        chk("t1_wins",  72'(wins[0]),  72'd9);
        chk("t1_dones", 72'(dones[0]), 72'd1);

        // Same frame, idle cycle before every pixel
        clear_counts();
        frame(0, 0, 1, 1'b1, 25);
        step(0, 1'b0, 1'b0, 8'd0);
        chk("t2_wins",  72'(wins[0]),  72'd9);
        chk("t2_dones", 72'(dones[0]), 72'd1);

        // Two back-to-back random frames, random idles
        clear_counts();
        frame(0, 1, 2, 1'b1, 25);
        frame(0, 1, 0, 1'b1, 25);
        step(0, 1'b0, 1'b0, 8'd0);
        chk("t3_wins",  72'(wins[0]),  72'd18);
        chk("t3_dones", 72'(dones[0]), 72'd2);

        // Restart with in_sof at pixel (2,3): only the (2,2) window of the
        // abandoned frame appears, and no done for it.
        clear_counts();
        frame(0, 1, 0, 1'b1, 2 * 5 + 3);
        frame(0, 1, 0, 1'b1, 25);
        step(0, 1'b0, 1'b0, 8'd0);
        chk("t4_wins",  72'(wins[0]),  72'd10);
        chk("t4_dones", 72'(dones[0]), 72'd1);

        // Reset in place of pixel (3,1)
        frame(0, 1, 0, 1'b1, 3 * 5 + 1);
        a_valid = 1'b0;
        a_sof   = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_zero(0, "midreset");
        #1 reset = 1'b0;
        model_reset();
        clear_counts();
        frame(0, 1, 2, 1'b1, 25);
        step(0, 1'b0, 1'b0, 8'd0);
        chk("t5_wins",  72'(wins[0]),  72'd9);
        chk("t5_dones", 72'(dones[0]), 72'd1);

        // Frame started without in_sof from idle
        clear_counts();
        frame(0, 1, 0, 1'b0, 25);
        step(0, 1'b0, 1'b0, 8'd0);
        chk("t6_wins",  72'(wins[0]),  72'd9);
        chk("t6_dones", 72'(dones[0]), 72'd1);

        // 3x3 image: exactly one window per frame
        clear_counts();
        frame(1, 0, 0, 1'b1, 9);
        step(1, 1'b0, 1'b0, 8'd0);
        chk("t7_wins",  72'(wins[1]),  72'd1);
        chk("t7_dones", 72'(dones[1]), 72'd1);
        chk("t7_row",   72'(b_row),    72'd1);
        chk("t7_col",   72'(b_col),    72'd1);
        clear_counts();
        frame(1, 1, 2, 1'b0, 9);
        step(1, 1'b0, 1'b0, 8'd0);
        chk("t8_wins",  72'(wins[1]),  72'd1);
        chk("t8_dones", 72'(dones[1]), 72'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_sobel_window_gen
`default_nettype wire
